// File: rtl/serial_pkg.sv
// Shared types and constants for the serial receiver.
package serial_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

endpackage

// File: rtl/serial_bit_timer.sv
// Per-bit cycle counter; half_tick marks the mid-start-bit sample, full_tick each later sample.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign half_tick = (cnt == CW'(CLKS_PER_BIT/2 - 1));
    assign full_tick = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/serial_rx_ctrl.sv
// 8N1 serial receiver with valid/ready byte output; define SERIAL_RX_PARITY_EN
// to add an even-parity bit between data and stop.
module serial_rx_ctrl
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    state_t                 state, nxt;
    logic                   sync1, sync2;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   clr, half_tick, full_tick;
    logic                   shift_en, idx_clr, deliver, ferr_set;
`ifdef SERIAL_RX_PARITY_EN
    logic                   perr_set, par_ld, par_bad;
`endif

    serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clr),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Timer is held clear whenever no bit is being timed, so every timed
    // state starts counting from zero.
    always_comb begin
        nxt      = state;
        clr      = 1'b0;
        shift_en = 1'b0;
        idx_clr  = 1'b0;
        deliver  = 1'b0;
        ferr_set = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        perr_set = 1'b0;
        par_ld   = 1'b0;
`endif
        case (state)
            IDLE: begin
                clr     = 1'b1;
                idx_clr = 1'b1;
                if (!sync2) nxt = START;
            end
            START: begin
                if (half_tick) begin
                    clr     = 1'b1;
                    idx_clr = 1'b1;
                    nxt     = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_tick) begin
                    clr      = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                        nxt = PARITY;
`else
                        nxt = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (full_tick) begin
                    clr      = 1'b1;
                    par_ld   = 1'b1;
                    perr_set = ^{shreg, sync2};
                    nxt      = STOP;
                end
            end
`endif
            STOP: begin
                if (full_tick) begin
                    clr = 1'b1;
                    if (sync2) begin
`ifdef SERIAL_RX_PARITY_EN
                        deliver = !par_bad;
`else
                        deliver = 1'b1;
`endif
                        nxt = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        nxt      = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                clr = 1'b1;
                if (sync2) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync1     <= data;
            sync2     <= sync1;
            frame_err <= ferr_set;
            overrun   <= 1'b0;
            if (idx_clr)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + 1'b1;
            if (shift_en)
                shreg <= {sync2, shreg[DATA_BITS-1:1]};
            // A byte arriving while the previous one is unconsumed is dropped.
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_byte  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_set;
            if (par_ld) par_bad <= perr_set;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Directed bench for serial_rx_ctrl at CLKS_PER_BIT=16; honours SERIAL_RX_PARITY_EN.
module tb_serial_rx_ctrl;

    localparam int C = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int LAT = 155 + C;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid, busy, frame_err, overrun, parity_err;

    int vec = 0;
    int err = 0;
    int cyc = 0;
    int t_fall = 0;
    int t_valid = -1, t_bfall = -1;
    int n_valid = 0, n_busy = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
    logic pv = 1'b0, pb = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    logic perr_inj = 1'b0;
`endif

    serial_rx_ctrl #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (rx_valid && !pv) t_valid = cyc;
        if (!busy && pb) t_bfall = cyc;
        if (busy) n_busy++;
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (parity_err) n_perr++;
        pv = rx_valid;
        pb = busy;
    end

    task automatic drive_bit(input logic v);
        data = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic tx_frame(input logic [7:0] b, input logic stopv);
        @(posedge clk);
        #1;
        t_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef SERIAL_RX_PARITY_EN
        drive_bit((^b) ^ perr_inj);
`endif
        drive_bit(stopv);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec++; if (rx_valid !== 1'b0)   begin err++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        vec++; if (rx_byte !== 8'h00)   begin err++; $display("FAIL reset_rx_byte got %h want 00", rx_byte); end
        vec++; if (busy !== 1'b0)       begin err++; $display("FAIL reset_busy got %b want 0", busy); end
        vec++; if (frame_err !== 1'b0)  begin err++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        vec++; if (overrun !== 1'b0)    begin err++; $display("FAIL reset_overrun got %b want 0", overrun); end
        vec++; if (parity_err !== 1'b0) begin err++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic;
        int bv, bf, bo;
        bv = n_valid; bf = n_ferr; bo = n_ovr;
        tx_frame(8'hA5, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        vec++; if (t_valid - t_fall !== LAT) begin err++; $display("FAIL basic_latency got %0d want %0d", t_valid - t_fall, LAT); end
        vec++; if (rx_byte !== 8'hA5) begin err++; $display("FAIL basic_byte got %h want a5", rx_byte); end
        vec++; if (n_valid - bv !== 1) begin err++; $display("FAIL basic_valid_cycles got %0d want 1", n_valid - bv); end
        vec++; if (t_bfall !== t_valid) begin err++; $display("FAIL basic_busy_fall got %0d want %0d", t_bfall, t_valid); end
        vec++; if (n_ferr - bf !== 0) begin err++; $display("FAIL basic_frame_err got %0d want 0", n_ferr - bf); end
        vec++; if (n_ovr - bo !== 0) begin err++; $display("FAIL basic_overrun got %0d want 0", n_ovr - bo); end
    endtask

    task automatic test_glitch;
        int bv, bf, bb, bp;
        bv = n_valid; bf = n_ferr; bb = n_busy; bp = n_perr;
        @(posedge clk);
        #1 data = 1'b0;
        repeat (4) @(posedge clk);
        #1 data = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        vec++; if (n_busy - bb !== 8) begin err++; $display("FAIL glitch_start_cycles got %0d want 8", n_busy - bb); end
        vec++; if (n_valid - bv !== 0) begin err++; $display("FAIL glitch_valid got %0d want 0", n_valid - bv); end
        vec++; if (n_ferr - bf !== 0) begin err++; $display("FAIL glitch_frame_err got %0d want 0", n_ferr - bf); end
        vec++; if (n_perr - bp !== 0) begin err++; $display("FAIL glitch_parity_err got %0d want 0", n_perr - bp); end
    endtask

    task automatic test_frame_err;
        int bv, bf;
        bv = n_valid; bf = n_ferr;
        tx_frame(8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        vec++; if (n_ferr - bf !== 1) begin err++; $display("FAIL ferr_pulses got %0d want 1", n_ferr - bf); end
        vec++; if (n_valid - bv !== 0) begin err++; $display("FAIL ferr_valid got %0d want 0", n_valid - bv); end
        vec++; if (busy !== 1'b1) begin err++; $display("FAIL ferr_wait_high_busy got %b want 1", busy); end
        @(posedge clk);
        #1 data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL ferr_idle_after_high got %b want 0", busy); end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_back_to_back;
        int bo;
        bo = n_ovr;
        rx_ready = 1'b0;
        tx_frame(8'h3C, 1'b1);
        tx_frame(8'hC3, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        vec++; if (rx_valid !== 1'b1) begin err++; $display("FAIL ovr_valid_held got %b want 1", rx_valid); end
        vec++; if (rx_byte !== 8'h3C) begin err++; $display("FAIL ovr_byte_kept got %h want 3c", rx_byte); end
        vec++; if (n_ovr - bo !== 1) begin err++; $display("FAIL ovr_pulses got %0d want 1", n_ovr - bo); end
        bo = n_ovr;
        // accept the old byte exactly on the delivery edge of the new one
        fork
            tx_frame(8'h96, 1'b1);
            begin
                @(posedge clk);
                repeat (LAT - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        repeat (5) @(posedge clk);
        @(negedge clk);
        vec++; if (rx_byte !== 8'h96) begin err++; $display("FAIL same_cycle_byte got %h want 96", rx_byte); end
        vec++; if (rx_valid !== 1'b1) begin err++; $display("FAIL same_cycle_valid got %b want 1", rx_valid); end
        vec++; if (n_ovr - bo !== 0) begin err++; $display("FAIL same_cycle_overrun got %0d want 0", n_ovr - bo); end
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vec++; if (rx_valid !== 1'b0) begin err++; $display("FAIL consume_valid got %b want 0", rx_valid); end
        repeat (10) @(posedge clk);
    endtask

    task automatic test_reset_midframe;
        int bv, bf, bp;
        bv = n_valid; bf = n_ferr; bp = n_perr;
        fork
            tx_frame(8'hF8, 1'b1);
            begin
                @(posedge clk);
                repeat (85) @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                vec++; if (busy !== 1'b0)       begin err++; $display("FAIL mid_rst_busy got %b want 0", busy); end
                vec++; if (rx_valid !== 1'b0)   begin err++; $display("FAIL mid_rst_valid got %b want 0", rx_valid); end
                vec++; if (rx_byte !== 8'h00)   begin err++; $display("FAIL mid_rst_byte got %h want 00", rx_byte); end
                vec++; if (frame_err !== 1'b0)  begin err++; $display("FAIL mid_rst_frame_err got %b want 0", frame_err); end
                vec++; if (overrun !== 1'b0)    begin err++; $display("FAIL mid_rst_overrun got %b want 0", overrun); end
                vec++; if (parity_err !== 1'b0) begin err++; $display("FAIL mid_rst_parity_err got %b want 0", parity_err); end
                repeat (4) @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        @(negedge clk);
        vec++; if (n_valid - bv !== 0) begin err++; $display("FAIL abandoned_valid got %0d want 0", n_valid - bv); end
        vec++; if (n_ferr - bf !== 0)  begin err++; $display("FAIL abandoned_frame_err got %0d want 0", n_ferr - bf); end
        bv = n_valid;
        tx_frame(8'h5A, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        vec++; if (rx_byte !== 8'h5A)   begin err++; $display("FAIL post_rst_byte got %h want 5a", rx_byte); end
        vec++; if (n_valid - bv !== 1)  begin err++; $display("FAIL post_rst_valid got %0d want 1", n_valid - bv); end
        vec++; if (n_ferr - bf !== 0)   begin err++; $display("FAIL post_rst_frame_err got %0d want 0", n_ferr - bf); end
        vec++; if (n_perr - bp !== 0)   begin err++; $display("FAIL post_rst_parity_err got %0d want 0", n_perr - bp); end
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity;
        int bv, bp, bf;
        bv = n_valid; bp = n_perr; bf = n_ferr;
        perr_inj = 1'b1;
        tx_frame(8'h01, 1'b1);
        perr_inj = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        vec++; if (n_perr - bp !== 1)  begin err++; $display("FAIL parity_bad_pulse got %0d want 1", n_perr - bp); end
        vec++; if (n_valid - bv !== 0) begin err++; $display("FAIL parity_bad_valid got %0d want 0", n_valid - bv); end
        vec++; if (n_ferr - bf !== 0)  begin err++; $display("FAIL parity_bad_frame_err got %0d want 0", n_ferr - bf); end
        bp = n_perr;
        tx_frame(8'h01, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        vec++; if (rx_byte !== 8'h01)  begin err++; $display("FAIL parity_good_byte got %h want 01", rx_byte); end
        vec++; if (n_valid - bv !== 1) begin err++; $display("FAIL parity_good_valid got %0d want 1", n_valid - bv); end
        vec++; if (n_perr - bp !== 0)  begin err++; $display("FAIL parity_good_pulse got %0d want 0", n_perr - bp); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
